// File: rtl/divider_sweep_controller_if.sv
// Request, configuration and status signals of the divider sweep controller.
// The master modport is the requester side, and the slave modport is the controller side.
interface divider_sweep_controller_if #(
  parameter int unsigned DIV_WIDTH   = 10,
  parameter int unsigned DWELL_WIDTH = 16
);
  logic                   start;
  logic                   stop;
  logic [DIV_WIDTH-1:0]   cfg_min_half;
  logic [DIV_WIDTH-1:0]   cfg_max_half;
  logic [DIV_WIDTH-1:0]   cfg_step;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic [1:0]             cfg_mode;
  logic                   clock_out;
  logic                   period_tick;
  logic [DIV_WIDTH-1:0]   half_cur;
  logic                   busy;
  logic                   sweep_done;
  logic                   cfg_error;

  modport master (
    output start, stop, cfg_min_half, cfg_max_half, cfg_step, cfg_dwell, cfg_mode,
    input  clock_out, period_tick, half_cur, busy, sweep_done, cfg_error
  );

  modport slave (
    input  start, stop, cfg_min_half, cfg_max_half, cfg_step, cfg_dwell, cfg_mode,
    output clock_out, period_tick, half_cur, busy, sweep_done, cfg_error
  );
endinterface

// File: rtl/divider_sweep_controller.sv
// 50%-duty programmable clock divider that sweeps its half-divisor between min and max.
// Divisor changes and stops are applied only at output period boundaries.
module divider_sweep_controller #(
  parameter int unsigned DIV_WIDTH   = 10,
  parameter int unsigned DWELL_WIDTH = 16
) (
  input  logic                      clock_in,
  input  logic                      reset,
  divider_sweep_controller_if.slave bus
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] STOPPING = 2'd2;

  localparam int unsigned CW = DIV_WIDTH + 1;
  localparam logic [CW-1:0]          CW_ONE = 1;
  localparam logic [DWELL_WIDTH-1:0] DW_ONE = 1;

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          counter_q, counter_d;
  logic [DIV_WIDTH-1:0]   half_q, half_d;
  logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
  logic                   dir_down_q, dir_down_d;
  logic                   clk_out_q, clk_out_d;
  logic                   sweep_done_q, sweep_done_d;
  logic                   cfg_error_q, cfg_error_d;
  logic [DIV_WIDTH-1:0]   min_q, min_d;
  logic [DIV_WIDTH-1:0]   max_q, max_d;
  logic [DIV_WIDTH-1:0]   step_q, step_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [1:0]             mode_q, mode_d;

  logic [CW-1:0]          half_ext, min_ext, max_ext, step_ext;
  logic [CW-1:0]          period_m1, counter_n, up_nxt, dn_nxt;
  logic [DWELL_WIDTH-1:0] dwell_last;
  logic                   active, wrap, cfg_valid, dn_underflow;
  logic [DIV_WIDTH-1:0]   adv_half;
  logic                   adv_dir_down, adv_finish;

  assign half_ext     = {1'b0, half_q};
  assign min_ext      = {1'b0, min_q};
  assign max_ext      = {1'b0, max_q};
  assign step_ext     = {1'b0, step_q};
  assign period_m1    = (half_ext << 1) - CW_ONE;
  assign active       = (state_q != IDLE);
  assign wrap         = active && (counter_q == period_m1);
  assign counter_n    = wrap ? '0 : counter_q + CW_ONE;
  assign up_nxt       = half_ext + step_ext;
  assign dn_nxt       = half_ext - step_ext;
  assign dn_underflow = (half_ext < step_ext);
  assign dwell_last   = (dwell_q == '0) ? '0 : dwell_q - DW_ONE;
  assign cfg_valid    = (bus.cfg_min_half != '0) && (bus.cfg_step != '0) &&
                        (bus.cfg_min_half <= bus.cfg_max_half);

  // Next half-divisor once the dwell expires; a bounce that cannot move keeps the current value.
  always_comb begin
    adv_half     = half_q;
    adv_dir_down = dir_down_q;
    adv_finish   = 1'b0;
    if (!dir_down_q) begin
      if (up_nxt > max_ext) begin
        case (mode_q)
          2'd1: adv_half = min_q;
          2'd2: begin
            adv_dir_down = 1'b1;
            if (!dn_underflow && (dn_nxt >= min_ext)) adv_half = dn_nxt[DIV_WIDTH-1:0];
          end
          default: adv_finish = 1'b1;
        endcase
      end else begin
        adv_half = up_nxt[DIV_WIDTH-1:0];
      end
    end else begin
      if (dn_underflow || (dn_nxt < min_ext)) begin
        adv_dir_down = 1'b0;
        if (up_nxt <= max_ext) adv_half = up_nxt[DIV_WIDTH-1:0];
      end else begin
        adv_half = dn_nxt[DIV_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    half_d       = half_q;
    dwell_cnt_d  = dwell_cnt_q;
    dir_down_d   = dir_down_q;
    clk_out_d    = clk_out_q;
    sweep_done_d = 1'b0;
    cfg_error_d  = 1'b0;
    min_d        = min_q;
    max_d        = max_q;
    step_d       = step_q;
    dwell_d      = dwell_q;
    mode_d       = mode_q;

    if (state_q == IDLE) begin
      if (bus.start) begin
        if (cfg_valid) begin
          min_d       = bus.cfg_min_half;
          max_d       = bus.cfg_max_half;
          step_d      = bus.cfg_step;
          dwell_d     = bus.cfg_dwell;
          mode_d      = bus.cfg_mode;
          half_d      = bus.cfg_min_half;
          counter_d   = '0;
          dwell_cnt_d = '0;
          dir_down_d  = 1'b0;
          clk_out_d   = 1'b1;
          state_d     = RUN;
        end else begin
          cfg_error_d = 1'b1;
        end
      end
    end else begin
      counter_d = counter_n;
      clk_out_d = (counter_n < half_ext);
      if (wrap) begin
        // A pending stop, a stop on this edge and a one-shot finish all share one exit.
        if ((state_q == STOPPING) || bus.stop ||
            ((dwell_cnt_q == dwell_last) && adv_finish)) begin
          state_d      = IDLE;
          counter_d    = '0;
          dwell_cnt_d  = '0;
          clk_out_d    = 1'b0;
          sweep_done_d = 1'b1;
        end else if (dwell_cnt_q == dwell_last) begin
          dwell_cnt_d = '0;
          half_d      = adv_half;
          dir_down_d  = adv_dir_down;
        end else begin
          dwell_cnt_d = dwell_cnt_q + DW_ONE;
        end
      end else if (bus.stop && (state_q == RUN)) begin
        state_d = STOPPING;
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      half_q       <= '0;
      dwell_cnt_q  <= '0;
      dir_down_q   <= 1'b0;
      clk_out_q    <= 1'b0;
      sweep_done_q <= 1'b0;
      cfg_error_q  <= 1'b0;
      min_q        <= '0;
      max_q        <= '0;
      step_q       <= '0;
      dwell_q      <= '0;
      mode_q       <= '0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      half_q       <= half_d;
      dwell_cnt_q  <= dwell_cnt_d;
      dir_down_q   <= dir_down_d;
      clk_out_q    <= clk_out_d;
      sweep_done_q <= sweep_done_d;
      cfg_error_q  <= cfg_error_d;
      min_q        <= min_d;
      max_q        <= max_d;
      step_q       <= step_d;
      dwell_q      <= dwell_d;
      mode_q       <= mode_d;
    end
  end

  assign bus.clock_out   = clk_out_q;
  assign bus.period_tick = wrap;
  assign bus.half_cur    = half_q;
  assign bus.busy        = active;
  assign bus.sweep_done  = sweep_done_q;
  assign bus.cfg_error   = cfg_error_q;
endmodule

// File: tb/tb_divider_sweep_controller.sv
// Scoreboard bench: stimulus queues expected periods and pulses, and a negedge monitor
// measures clock_out periods and pulses and then compares them against the queue.
module tb_divider_sweep_controller;
  localparam int unsigned DW  = 10;
  localparam int unsigned DWL = 16;
  localparam int EV_PERIOD = 0;
  localparam int EV_DONE   = 1;
  localparam int EV_ERR    = 2;

  typedef struct {
    int kind;
    int half;
  } ev_t;

  logic clock_in = 1'b0;
  logic reset;

  divider_sweep_controller_if #(.DIV_WIDTH(DW), .DWELL_WIDTH(DWL)) bus ();

  divider_sweep_controller #(.DIV_WIDTH(DW), .DWELL_WIDTH(DWL)) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clock_in = ~clock_in;

  ev_t sb[$];
  int  m_halves[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: list of half-divisors, one per output period, and the run length in cycles.
  // The argument n is the cycle in which stop is asserted; it only matters when n >= 1.
  function automatic int build_model(input int mn, input int mx, input int st,
                                     input int dw, input int md, input int n);
    int h, s, dwe;
    bit down;
    m_halves.delete();
    dwe  = (dw == 0) ? 1 : dw;
    h    = mn;
    down = 1'b0;
    s    = 1;
    for (int guard = 0; guard < 1000; guard++) begin
      for (int r = 0; r < dwe; r++) begin
        if (n >= 1 && s > n) return s - 1;
        m_halves.push_back(h);
        s += 2 * h;
      end
      if (!down) begin
        if (h + st > mx) begin
          if (md == 2) begin
            down = 1'b1;
            if (h - st >= mn) h -= st;
          end else if (md == 1) begin
            h = mn;
          end else begin
            return s - 1;
          end
        end else begin
          h += st;
        end
      end else begin
        if (h - st < mn) begin
          down = 1'b0;
          if (h + st <= mx) h += st;
        end else begin
          h -= st;
        end
      end
    end
    return s - 1;
  endfunction

  // Monitor
  bit prev_co, prev_busy, prev_tick, in_per;
  int hi_cnt, lo_cnt, tick_cnt, half_seen;

  task automatic expect_event(input int kind, input string name);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got event kind %0d expected none", name, kind);
    end else begin
      e = sb.pop_front();
      check({name, "_kind"}, kind, e.kind);
    end
  endtask

  task automatic close_period();
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_period: got half %0d expected none", half_seen);
    end else begin
      e = sb.pop_front();
      check("period_kind", EV_PERIOD, e.kind);
      check("period_high", hi_cnt, e.half);
      check("period_low", lo_cnt, e.half);
      check("period_half_cur", half_seen, e.half);
      check("tick_count", tick_cnt, 1);
      check("tick_last", int'(prev_tick), 1);
    end
  endtask

  always @(negedge clock_in) begin : mon
    bit rise, busy_fall;
    if (reset) begin
      in_per    = 1'b0;
      prev_co   = 1'b0;
      prev_busy = 1'b0;
      prev_tick = 1'b0;
    end else begin
      rise      = bus.clock_out && !prev_co;
      busy_fall = !bus.busy && prev_busy;
      if (in_per && (rise || busy_fall)) begin
        close_period();
        in_per = 1'b0;
      end
      if (rise) begin
        in_per    = 1'b1;
        hi_cnt    = 0;
        lo_cnt    = 0;
        tick_cnt  = 0;
        half_seen = int'(bus.half_cur);
      end
      if (in_per) begin
        if (bus.clock_out) hi_cnt++;
        else lo_cnt++;
        if (bus.period_tick) tick_cnt++;
      end
      if (bus.sweep_done) expect_event(EV_DONE, "sweep_done");
      if (bus.cfg_error) expect_event(EV_ERR, "cfg_error");
      prev_co   = bus.clock_out;
      prev_busy = bus.busy;
      prev_tick = bus.period_tick;
    end
  end

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic set_cfg(input int mn, input int mx, input int st, input int dw, input int md);
    bus.cfg_min_half = DW'(mn);
    bus.cfg_max_half = DW'(mx);
    bus.cfg_step     = DW'(st);
    bus.cfg_dwell    = DWL'(dw);
    bus.cfg_mode     = 2'(md);
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      tick();
      waited++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d pending events expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Stop is asserted in cycle n (0 = with start, -1 = never). With bs_en set, start is pulsed again mid-run.
  task automatic run_sweep(input int mn, input int mx, input int st, input int dw,
                           input int md, input int n, input bit bs_en);
    int len, limit, bs;
    ev_t e;
    len = build_model(mn, mx, st, dw, md, n);
    foreach (m_halves[i]) begin
      e.kind = EV_PERIOD;
      e.half = m_halves[i];
      sb.push_back(e);
    end
    e.kind = EV_DONE;
    e.half = 0;
    sb.push_back(e);
    bs = (bs_en && len > 1) ? int'($urandom_range(1, len - 1)) : -1;
    set_cfg(mn, mx, st, dw, md);
    bus.start = 1'b1;
    bus.stop  = (n == 0);
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    limit = ((n > len) ? n : len) + 2;
    for (int c = 1; c <= limit; c++) begin
      bus.stop  = (c == n);
      bus.start = (c == bs);
      set_cfg(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 3)));
      tick();
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    drain("sweep");
    check("end_busy", int'(bus.busy), 0);
    check("end_clock_out", int'(bus.clock_out), 0);
  endtask

  task automatic run_invalid(input int mn, input int mx, input int st);
    ev_t e;
    e.kind = EV_ERR;
    e.half = 0;
    sb.push_back(e);
    set_cfg(mn, mx, st, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("invalid_busy", int'(bus.busy), 0);
      check("invalid_clock_out", int'(bus.clock_out), 0);
      tick();
    end
    drain("invalid");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mn, mx, st, dw, md, n;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (2) @(posedge clock_in);
    #1;
    check("rst_clock_out", int'(bus.clock_out), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_half_cur", int'(bus.half_cur), 0);
    check("rst_period_tick", int'(bus.period_tick), 0);
    check("rst_sweep_done", int'(bus.sweep_done), 0);
    check("rst_cfg_error", int'(bus.cfg_error), 0);
    reset = 1'b0;
    tick();

    run_sweep(1, 3, 1, 2, 0, -1, 1'b0);
    run_sweep(2, 5, 3, 1, 3, 0, 1'b0);
    run_sweep(2, 4, 2, 1, 2, 30, 1'b1);
    run_sweep(3, 5, 2, 1, 1, 8, 1'b0);
    run_sweep(3, 5, 2, 1, 1, 6, 1'b0);
    run_sweep(1, 2, 1, 1, 0, 6, 1'b0);
    run_sweep(2, 4, 1, 0, 0, -1, 1'b1);
    run_sweep(1, 1, 3, 1, 2, 20, 1'b0);

    run_invalid(4, 2, 1);
    run_invalid(2, 4, 0);
    run_invalid(0, 4, 1);

    // Asynchronous reset in the middle of a high phase.
    set_cfg(5, 8, 1, 1, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("pre_reset_clock_out", int'(bus.clock_out), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_clock_out", int'(bus.clock_out), 0);
    check("async_busy", int'(bus.busy), 0);
    check("async_half_cur", int'(bus.half_cur), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    run_sweep(1, 3, 1, 2, 0, -1, 1'b0);

    for (int i = 0; i < 25; i++) begin
      mn = int'($urandom_range(1, 8));
      mx = int'($urandom_range(mn, 10));
      st = int'($urandom_range(1, 4));
      dw = int'($urandom_range(0, 3));
      md = int'($urandom_range(0, 3));
      n  = (md == 1 || md == 2) ? int'($urandom_range(1, 150)) : int'($urandom_range(0, 150));
      run_sweep(mn, mx, st, dw, md, n, 1'b1);
      repeat (int'($urandom_range(0, 3))) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
